// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, default datapath widths and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;
  localparam int OPCODE_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_LT   = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_ST   = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_LD   = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_SLI  = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_BR   = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_JUMP = 4'd10;

  // IDLE only follows reset; DRAIN waits out a read made obsolete by a redirect.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, decode-stage output
// and the redirect input from branch/jump resolution.
//
// Handshakes:
//   imem: imem_req is held high with a stable imem_addr until imem_ack; the
//         read completes in the cycle imem_ack=1 (imem_rdata valid then).
//   id:   id_valid/id_instr/id_pc stay frozen until id_ready=1 is seen on a
//         rising edge while id_valid=1; that edge completes the transfer.
interface instr_fetch_if import cpu_pkg::*; #(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;

  logic                id_valid;
  logic                id_ready;
  logic [INSTR_W-1:0]  id_instr;
  logic [OPCODE_W-1:0] id_opcode;
  logic [PC_W-1:0]     id_pc;

  logic                redirect;
  logic [PC_W-1:0]     redirect_pc;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
    input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );

  // Memory / decode / branch-resolution side.
  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_opcode, id_pc,
    output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory one word at
// a time and hands each instruction (with its opcode) to decode. Redirects
// replace the PC; a read already in flight is drained and its data dropped.
module instr_fetch import cpu_pkg::*; #(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus,
  output fetch_state_e  state_o
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    stale_q, stale_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;

  // Next-state and datapath updates; redirect outranks ack and id_ready.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          if (!bus.imem_ack) begin
            // Memory still owes us the old read: keep presenting its address.
            stale_d = pc_q;
            state_d = DRAIN;
          end
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          id_pc_d = pc_q;
          pc_d    = pc_q + PC_W'(1);
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (bus.id_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end else if (bus.imem_ack) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears imem_req/id_valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      id_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = (state_q == DRAIN) ? stale_q : pc_q;
  assign bus.id_valid  = valid_q;
  assign bus.id_instr  = instr_q;
  assign bus.id_opcode = instr_q[INSTR_W-1 -: OPCODE_W];
  assign bus.id_pc     = id_pc_q;
  assign state_o       = state_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 4-bit-opcode MIPS-style CPU. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction with its opcode field to the decode stage, where the control unit consumes it. It accepts PC redirects from the branch/jump resolution logic and discards wrong-path fetches.

## Interface
Parameters:
- PC_W, 16, program counter and instruction-memory word-address width
- INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1 -: 4]
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request, held high until imem_ack
- imem_addr  out  PC_W  word address; stable while imem_req=1
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  instruction word
- id_valid  out  1  id_instr/id_opcode/id_pc hold a valid instruction
- id_ready  in  1  decode stage accepts the instruction this cycle
- id_instr  out  INSTR_W  registered instruction word
- id_opcode  out  4  id_instr[INSTR_W-1 -: 4]; drives the control unit Opcode input
- id_pc  out  PC_W  address the instruction was fetched from
- redirect  in  1  taken branch or jump; load redirect_pc
- redirect_pc  in  PC_W  new fetch address

## Operation
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- The PC is word-addressed. Increment is +1 modulo 2^PC_W: 0xFFFF wraps to 0x0000.
- IDLE: entered only from reset. Moves to REQ on the next edge.
- REQ: imem_req=1 and imem_addr=pc.
  - On imem_ack: capture imem_rdata into id_instr and pc into id_pc, set pc<=pc+1, set id_valid<=1, and go to HOLD.
  - No ack: stay in REQ.
- HOLD: imem_req=0, id_valid=1, and the outputs are frozen.
  - On id_ready: id_valid<=0 and go to REQ.
- DRAIN: imem_req=1 with the stale address; wait for imem_ack, discard the data, then go to REQ. pc already holds the redirect target.
- redirect has priority over every other event in every state except IDLE:
  - HOLD: pc<=redirect_pc, id_valid<=0, go to REQ. If id_ready is high in the same cycle, the handshake still counts as complete.
  - REQ with imem_ack in the same cycle: discard the data, pc<=redirect_pc, stay in REQ.
  - REQ without imem_ack: pc<=redirect_pc, go to DRAIN. imem_addr stays at the old address until the ack arrives.
  - DRAIN: pc<=redirect_pc, stay in DRAIN. The last redirect wins.
- An imem_ack outside REQ or DRAIN is ignored.
- Reset mid-transaction: imem_req drops immediately, asynchronously. Instruction memory must abandon any in-flight read on rst.

## Timing
- Fetch latency: an ack at edge N produces id_valid=1 after edge N.
- Zero-wait memory (ack in the first REQ cycle): one instruction every 2 cycles when id_ready is held at 1.
- Redirect to target visible: a redirect at edge N drives imem_addr=redirect_pc from cycle N+1, unless the block is in DRAIN.
- All outputs are registered except imem_addr. imem_addr is muxed from pc, or from the stale address while in DRAIN.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_LT=2, OP_OR=3, OP_AND=4, OP_SHL=5, OP_ST=6, OP_LD=7, OP_SLI=8, OP_BR=9, OP_JUMP=10
  - PC_W and INSTR_W defaults
  - the fetch state enum {IDLE, REQ, HOLD, DRAIN}
- A single module is sufficient; no sub-module is needed. The PC incrementer is inline.

## Test plan
- Reset then a zero-wait memory returning 0x0123 at address 0 and 0x1456 at address 1, id_ready=1 -> id_opcode=0 with id_pc=0, then id_opcode=1 with id_pc=1; id_valid pulses every 2 cycles.
- id_ready=0 for 5 cycles in HOLD -> id_instr, id_pc and id_valid stay stable; imem_req=0 throughout.
- A 3-cycle ack delay with redirect=1, redirect_pc=0x0040 on the first REQ cycle -> DRAIN, imem_addr stays at the old PC until the ack, that data is dropped, and the next request is to 0x0040 with no id_valid in between.
- Redirect and id_ready together in HOLD at id_pc=0x0010 with redirect_pc=0x0003 -> id_valid=0 next cycle and the next imem_addr is 0x0003.
- pc=0xFFFF fetched and accepted -> the next imem_addr is 0x0000.
- rst asserted while imem_req=1 mid-wait -> imem_req and id_valid go to 0 without waiting for a clock edge; after release the first request is to RESET_PC.
